// File: rtl/uart_hex_display_pkg.sv
// Shared constants for the UART hex display slice.
//   BYTE_W / NIB_W      : byte and nibble widths used for digit packing.
//   SEG_BLANK           : seven-segment pattern with every segment off
//                         (active-low segments on the DE2 board).
//   CLK_HZ              : board clock frequency.
//   ACT_CYCLES_DEFAULT  : 100 ms activity stretch at CLK_HZ.
//   apply_blank()       : helper for the board top level, placed between a
//                         digit decoder and the pins.
package uart_hex_display_pkg;

    localparam int BYTE_W = 8;
    localparam int NIB_W  = 4;

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    localparam int CLK_HZ             = 50_000_000;
    localparam int ACT_MS             = 100;
    localparam int ACT_CYCLES_DEFAULT = (CLK_HZ / 1000) * ACT_MS;

    // Forces a decoded digit dark when its blank bit is set.
    function automatic logic [6:0] apply_blank(input logic [6:0] seg, input logic blank);
        return blank ? SEG_BLANK : seg;
    endfunction

endpackage

// File: rtl/uart_hex_display_if.sv
// Byte strobe bus from the UART receiver.
//   rx_data  : received byte
//   rx_valid : one-cycle strobe, rx_data valid
//   rx_err   : framing error qualifying the same strobe
// master = receiver side, slave = consumer side.
interface uart_hex_display_if;
    import uart_hex_display_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_err;

    modport master (output rx_data, output rx_valid, output rx_err);
    modport slave  (input  rx_data, input  rx_valid, input  rx_err);

endinterface

// File: rtl/uart_hex_display_pulse_stretch.sv
// pulse_stretch: turns a single-cycle trigger into a level that stays high
// for exactly ACT_CYCLES cycles after the most recent trigger.
//   clk, rst : clock, asynchronous active-high reset
//   trig     : reload the counter to ACT_CYCLES
//   active   : registered, high while the counter is non-zero
module pulse_stretch #(
    parameter int ACT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic active
);

    localparam int CW = $clog2(ACT_CYCLES + 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic          active_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (trig) begin
            cnt_next = CW'(ACT_CYCLES);
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    // active follows the next count so it rises in the same cycle the counter
    // loads: high for cycles where the count is ACT_CYCLES down to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            active_reg <= (cnt_next != '0);
        end
    end

    assign active = active_reg;

endmodule

// File: rtl/uart_hex_display.sv
// uart_hex_display: byte history for the DE2 seven-segment digits.
//   clk, rst    : clock, asynchronous active-high reset
//   rx          : byte strobe bus from the UART receiver (slave side)
//   hold        : freeze display, ignore good bytes
//   clear       : synchronous clear of history, fill, counter, error flag
//   digit_nib   : nibble per digit, digit k at [4k+3:4k], newest byte lowest
//   digit_blank : 1 = digit k must be driven dark
//   byte_count  : accepted bytes, wraps
//   activity    : stretched receive indicator
//   err_flag    : sticky framing error
module uart_hex_display
    import uart_hex_display_pkg::*;
#(
    parameter int NUM_BYTES  = 4,
    parameter int ACT_CYCLES = ACT_CYCLES_DEFAULT,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_hex_display_if.slave           rx,
    input  logic                        hold,
    input  logic                        clear,
    output logic [BYTE_W*NUM_BYTES-1:0] digit_nib,
    output logic [2*NUM_BYTES-1:0]      digit_blank,
    output logic [CNT_W-1:0]            byte_count,
    output logic                        activity,
    output logic                        err_flag
);

    localparam int FILL_W = $clog2(NUM_BYTES + 1);

    logic                        accept;
    logic                        err_strobe;
    logic [BYTE_W*NUM_BYTES-1:0] hist_reg, hist_next;
    logic [FILL_W-1:0]           fill_reg, fill_next;
    logic [2*NUM_BYTES-1:0]      blank_reg, blank_next;
    logic [CNT_W-1:0]            count_reg, count_next;
    logic                        err_reg, err_next;

    assign accept     = rx.rx_valid & ~rx.rx_err & ~hold & ~clear;
    assign err_strobe = rx.rx_valid &  rx.rx_err & ~clear;

    // Byte slot gi occupies digits 2gi and 2gi+1, so the history vector maps
    // straight onto digit_nib. Each slot loads from the slot below it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
            logic [BYTE_W-1:0] shift_in;
            if (gi == 0) begin : g_first
                assign shift_in = rx.rx_data;
            end else begin : g_rest
                assign shift_in = hist_reg[BYTE_W*(gi-1) +: BYTE_W];
            end

            assign hist_next[BYTE_W*gi +: BYTE_W] =
                clear  ? '0 :
                accept ? shift_in :
                         hist_reg[BYTE_W*gi +: BYTE_W];

            // Blank is decoded from the next fill level so it lands in the
            // same cycle as the byte it describes.
            assign blank_next[2*gi +: 2] = {2{FILL_W'(gi) >= fill_next}};
        end
    endgenerate

    always_comb begin
        fill_next  = fill_reg;
        count_next = count_reg;
        err_next   = err_reg;
        if (clear) begin
            fill_next  = '0;
            count_next = '0;
            err_next   = 1'b0;
        end else begin
            if (accept) begin
                count_next = count_reg + 1'b1;
                if (fill_reg < FILL_W'(NUM_BYTES)) begin
                    fill_next = fill_reg + 1'b1;
                end
            end
            if (err_strobe) begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            blank_reg <= '1;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            blank_reg <= blank_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    // The activity counter deliberately ignores clear.
    pulse_stretch #(
        .ACT_CYCLES (ACT_CYCLES)
    ) u_act (
        .clk    (clk),
        .rst    (rst),
        .trig   (accept),
        .active (activity)
    );

    assign digit_nib   = hist_reg;
    assign digit_blank = blank_reg;
    assign byte_count  = count_reg;
    assign err_flag    = err_reg;

endmodule

// File: tb/tb_uart_hex_display.sv
// Testbench for uart_hex_display with NUM_BYTES=4, ACT_CYCLES=10, CNT_W=8.
// Reference model: a queue of shown bytes (newest first), a byte counter,
// a sticky error bit and the edge index of the last accepted byte.
module tb_uart_hex_display;

    localparam int NB  = 4;
    localparam int ACT = 10;
    localparam int CW  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            hold = 1'b0;
    logic            clear = 1'b0;
    logic [8*NB-1:0] digit_nib;
    logic [2*NB-1:0] digit_blank;
    logic [CW-1:0]   byte_count;
    logic            activity;
    logic            err_flag;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_hex_display_if rx_bus ();

    uart_hex_display #(
        .NUM_BYTES  (NB),
        .ACT_CYCLES (ACT),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx_bus),
        .hold        (hold),
        .clear       (clear),
        .digit_nib   (digit_nib),
        .digit_blank (digit_blank),
        .byte_count  (byte_count),
        .activity    (activity),
        .err_flag    (err_flag)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    int         m_cnt;
    bit         m_err;
    int         edge_n;
    int         last_acc;
    bit         have_acc;

    function automatic void model_reset();
        mq.delete();
        m_cnt    = 0;
        m_err    = 1'b0;
        have_acc = 1'b0;
        last_acc = 0;
    endfunction

    function automatic logic [8*NB-1:0] exp_nib();
        logic [8*NB-1:0] r = '0;
        for (int j = 0; j < mq.size(); j++) r[8*j +: 8] = mq[j];
        return r;
    endfunction

    function automatic logic [2*NB-1:0] exp_blank();
        logic [2*NB-1:0] r = '0;
        for (int j = mq.size(); j < NB; j++) r[2*j +: 2] = 2'b11;
        return r;
    endfunction

    function automatic logic exp_act();
        return have_acc && ((edge_n - last_acc) < ACT);
    endfunction

    // One clock cycle of stimulus; samples 1 ns after the edge.
    task automatic cyc(input logic v, input logic e, input logic [7:0] d, input logic c);
        rx_bus.rx_valid = v;
        rx_bus.rx_err   = e;
        rx_bus.rx_data  = d;
        clear           = c;
        @(posedge clk);
        #1;
        edge_n++;
        if (c) begin
            mq.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else if (v && e) begin
            m_err = 1'b1;
        end else if (v && !hold) begin
            mq.push_front(d);
            if (mq.size() > NB) void'(mq.pop_back());
            m_cnt    = (m_cnt + 1) % (1 << CW);
            last_acc = edge_n;
            have_acc = 1'b1;
        end
        $display("[TB] t=%0t v=%0b e=%0b d=%02h hold=%0b clr=%0b -> nib=%08h blank=%08b cnt=%0d act=%0b err=%0b",
                 $time, v, e, d, hold, c, digit_nib, digit_blank, byte_count, activity, err_flag);
        rx_bus.rx_valid = 1'b0;
        rx_bus.rx_err   = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        tests_run++;
        if (digit_nib !== '0) begin tests_failed++; $display("FAIL reset_nib got=%h want=0", digit_nib); end
        tests_run++;
        if (digit_blank !== 8'hFF) begin tests_failed++; $display("FAIL reset_blank got=%b want=11111111", digit_blank); end
        tests_run++;
        if (byte_count !== 8'd0) begin tests_failed++; $display("FAIL reset_count got=%0d want=0", byte_count); end
        tests_run++;
        if (activity !== 1'b0 || err_flag !== 1'b0) begin
            tests_failed++; $display("FAIL reset_leds got act=%b err=%b want 0 0", activity, err_flag);
        end
    endtask

    task automatic test_two_bytes();
        do_reset();
        send(8'h3A);
        tests_run++;
        if (digit_blank !== 8'b1111_1100) begin tests_failed++; $display("FAIL first_blank got=%b want=11111100", digit_blank); end
        send(8'hF1);
        tests_run++;
        if (digit_nib !== 32'h0000_3AF1) begin tests_failed++; $display("FAIL two_nib got=%h want=00003af1", digit_nib); end
        tests_run++;
        if (digit_blank !== 8'b1111_0000) begin tests_failed++; $display("FAIL two_blank got=%b want=11110000", digit_blank); end
        tests_run++;
        if (byte_count !== 8'd2) begin tests_failed++; $display("FAIL two_count got=%0d want=2", byte_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        tests_run++;
        if (digit_nib !== 32'h2233_4455) begin tests_failed++; $display("FAIL ovf_nib got=%h want=22334455", digit_nib); end
        tests_run++;
        if (digit_blank !== 8'h00) begin tests_failed++; $display("FAIL ovf_blank got=%b want=00000000", digit_blank); end
        tests_run++;
        if (byte_count !== 8'd5) begin tests_failed++; $display("FAIL ovf_count got=%0d want=5", byte_count); end
    endtask

    task automatic test_error_clear();
        do_reset();
        send(8'h12);
        cyc(1'b1, 1'b1, 8'h99, 1'b0);
        tests_run++;
        if (digit_nib !== 32'h0000_0012) begin tests_failed++; $display("FAIL err_nib got=%h want=00000012", digit_nib); end
        tests_run++;
        if (byte_count !== 8'd1) begin tests_failed++; $display("FAIL err_count got=%0d want=1", byte_count); end
        tests_run++;
        if (err_flag !== 1'b1) begin tests_failed++; $display("FAIL err_flag got=%b want=1", err_flag); end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        tests_run++;
        if (err_flag !== 1'b0 || digit_blank !== 8'hFF || byte_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL clr_after_err got err=%b blank=%b cnt=%0d want 0 11111111 0", err_flag, digit_blank, byte_count);
        end
    endtask

    task automatic test_hold();
        do_reset();
        hold = 1'b1;
        send(8'hAB);
        tests_run++;
        if (digit_nib !== '0 || digit_blank !== 8'hFF || byte_count !== 8'd0 || activity !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_ignore got nib=%h blank=%b cnt=%0d act=%b want 0 11111111 0 0",
                     digit_nib, digit_blank, byte_count, activity);
        end
        // Errors still register while held.
        cyc(1'b1, 1'b1, 8'h5A, 1'b0);
        tests_run++;
        if (err_flag !== 1'b1) begin tests_failed++; $display("FAIL hold_err got=%b want=1", err_flag); end
        hold = 1'b0;
        send(8'hCD);
        tests_run++;
        if (digit_nib[7:0] !== 8'hCD || byte_count !== 8'd1) begin
            tests_failed++; $display("FAIL unhold got low=%h cnt=%0d want cd 1", digit_nib[7:0], byte_count);
        end
    endtask

    task automatic test_activity();
        int highs;
        do_reset();
        highs = 0;
        send(8'h01);
        if (activity === 1'b1) highs++;
        for (int i = 0; i < 14; i++) begin
            idle(1);
            if (activity === 1'b1) highs++;
        end
        tests_run++;
        if (highs !== ACT) begin tests_failed++; $display("FAIL act_single got=%0d cycles want=%0d", highs, ACT); end

        highs = 0;
        send(8'h02);
        if (activity === 1'b1) highs++;
        for (int i = 1; i < 22; i++) begin
            if (i == 6) send(8'h03); else idle(1);
            if (activity === 1'b1) highs++;
            tests_run++;
            if (activity !== exp_act()) begin
                tests_failed++; $display("FAIL act_retrig_cyc%0d got=%b want=%b", i, activity, exp_act());
            end
        end
        tests_run++;
        if (highs !== 6 + ACT) begin tests_failed++; $display("FAIL act_retrig got=%0d cycles want=%0d", highs, 6 + ACT); end
    endtask

    task automatic test_clear_priority();
        do_reset();
        send(8'h41); send(8'h42);
        cyc(1'b1, 1'b0, 8'h77, 1'b1);
        tests_run++;
        if (digit_nib !== '0 || digit_blank !== 8'hFF || byte_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL clr_prio got nib=%h blank=%b cnt=%0d want 0 11111111 0", digit_nib, digit_blank, byte_count);
        end
        tests_run++;
        if (activity !== exp_act()) begin tests_failed++; $display("FAIL clr_keeps_act got=%b want=%b", activity, exp_act()); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            d = 8'(i * 7 + 3);
            send(d);
            if (i == 254) begin
                tests_run++;
                if (byte_count !== 8'd255) begin tests_failed++; $display("FAIL wrap_255 got=%0d want=255", byte_count); end
            end
        end
        tests_run++;
        if (byte_count !== 8'd0) begin tests_failed++; $display("FAIL wrap_0 got=%0d want=0", byte_count); end
        tests_run++;
        if (digit_nib !== exp_nib() || digit_blank !== 8'h00) begin
            tests_failed++; $display("FAIL wrap_hist got nib=%h blank=%b want %h 0", digit_nib, digit_blank, exp_nib());
        end
    endtask

    task automatic test_random();
        logic v, e, c;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v    = ($urandom_range(0, 1) == 1);
            e    = ($urandom_range(0, 7) == 0);
            c    = ($urandom_range(0, 31) == 0);
            hold = ($urandom_range(0, 7) == 0);
            d    = 8'($urandom);
            cyc(v, e, d, c);
            tests_run++;
            if (digit_nib !== exp_nib()) begin tests_failed++; $display("FAIL rnd_nib_%0d got=%h want=%h", i, digit_nib, exp_nib()); end
            tests_run++;
            if (digit_blank !== exp_blank()) begin tests_failed++; $display("FAIL rnd_blank_%0d got=%b want=%b", i, digit_blank, exp_blank()); end
            tests_run++;
            if (byte_count !== 8'(m_cnt)) begin tests_failed++; $display("FAIL rnd_cnt_%0d got=%0d want=%0d", i, byte_count, m_cnt); end
            tests_run++;
            if (activity !== exp_act()) begin tests_failed++; $display("FAIL rnd_act_%0d got=%b want=%b", i, activity, exp_act()); end
            tests_run++;
            if (err_flag !== m_err) begin tests_failed++; $display("FAIL rnd_err_%0d got=%b want=%b", i, err_flag, m_err); end
        end
        hold = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        send(8'hDE); send(8'hAD);
        cyc(1'b1, 1'b1, 8'h00, 1'b0);
        tests_run++;
        if (activity !== 1'b1 || err_flag !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_pre got act=%b err=%b want 1 1", activity, err_flag);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (digit_nib !== '0 || digit_blank !== 8'hFF || byte_count !== 8'd0 || activity !== 1'b0 || err_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst got nib=%h blank=%b cnt=%0d act=%b err=%b want 0 11111111 0 0 0",
                     digit_nib, digit_blank, byte_count, activity, err_flag);
        end
        #2;
        rst = 1'b0;
        model_reset();
        send(8'h5C);
        tests_run++;
        if (digit_nib !== 32'h0000_005C || byte_count !== 8'd1) begin
            tests_failed++; $display("FAIL midrst_after got nib=%h cnt=%0d want 0000005c 1", digit_nib, byte_count);
        end
    endtask

    initial begin
        rx_bus.rx_valid = 1'b0;
        rx_bus.rx_err   = 1'b0;
        rx_bus.rx_data  = 8'h00;
        edge_n = 0;
        model_reset();
        #12;
        test_reset();
        test_two_bytes();
        test_overflow();
        test_error_clear();
        test_hold();
        test_activity();
        test_clear_priority();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
